// File: rtl/icache_sa_miss_ctrl_if.sv
// CPU / storage / memory signal bundle for icache_sa_miss_ctrl.
// master = the controller, slave = the surrounding CPU, storage and memory.
interface icache_sa_miss_ctrl_if #(
    parameter int WORD_WIDTH    = 32,
    parameter int TAG_BITS      = 24,
    parameter int ASSOCIATIVITY = 2
);
    localparam int WAY_BITS = $clog2(ASSOCIATIVITY);

    logic                  cpu_req;
    logic [31:0]           cpu_addr;
    logic                  cpu_ready;
    logic                  cpu_valid;
    logic [WORD_WIDTH-1:0] cpu_rdata;
    logic                  flush;
    logic                  flush_done;

    logic                  st_read;
    logic                  st_write;
    logic                  st_write_valid;
    logic [31:0]           st_address;
    logic [WORD_WIDTH-1:0] st_write_data;
    logic [TAG_BITS-1:0]   st_write_tag;
    logic [WAY_BITS-1:0]   st_way_select;
    logic [WORD_WIDTH-1:0] st_read_data;
    logic                  st_hit;

    logic                  mem_req;
    logic [31:0]           mem_addr;
    logic                  mem_ack;
    logic [WORD_WIDTH-1:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_addr, flush, st_read_data, st_hit, mem_ack, mem_rdata,
        output cpu_ready, cpu_valid, cpu_rdata, flush_done,
               st_read, st_write, st_write_valid, st_address, st_write_data,
               st_write_tag, st_way_select, mem_req, mem_addr
    );

    modport slave (
        output cpu_req, cpu_addr, flush, st_read_data, st_hit, mem_ack, mem_rdata,
        input  cpu_ready, cpu_valid, cpu_rdata, flush_done,
               st_read, st_write, st_write_valid, st_address, st_write_data,
               st_write_tag, st_way_select, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_sa_miss_ctrl.sv
// Set-associative I-cache miss controller: lookup, memory refill with per-set
// round-robin victim, whole-cache flush. Optional ICACHE_SA_PERF_EN adds hit/miss counters.
module icache_sa_miss_ctrl #(
    parameter int WORD_WIDTH    = 32,
    parameter int INDEX_BITS    = 4,
    parameter int TAG_BITS      = 24,
    parameter int ASSOCIATIVITY = 2
) (
    input  logic clk,
    input  logic reset_n,
    icache_sa_miss_ctrl_if.master bus
`ifdef ICACHE_SA_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int NUM_SETS = 1 << INDEX_BITS;
    localparam int WAY_BITS = $clog2(ASSOCIATIVITY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_MEM_REQ = 3'd2,
        S_FILL    = 3'd3,
        S_RESP    = 3'd4,
        S_FLUSH   = 3'd5
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [31:0]                   r_addr_q;
    logic [WORD_WIDTH-1:0]         r_rdata;
    logic [INDEX_BITS-1:0]         r_set;
    logic [WAY_BITS-1:0]           r_way;
    logic                          r_flush_done;
    logic [NUM_SETS*WAY_BITS-1:0]  r_victim;
    logic [INDEX_BITS-1:0]         w_index;
    logic [WAY_BITS-1:0]           w_victim_cur;
    logic                          w_flush_last;

    assign w_index      = r_addr_q[INDEX_BITS-1:0];
    assign w_victim_cur = r_victim[int'(w_index)*WAY_BITS +: WAY_BITS];
    assign w_flush_last = (r_set == '1) && (r_way == '1);

    assign bus.cpu_valid  = (r_state == S_RESP);
    assign bus.cpu_rdata  = r_rdata;
    assign bus.flush_done = r_flush_done;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush wins over a simultaneous fetch in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.flush)        w_next = S_FLUSH;
                else if (bus.cpu_req) w_next = S_LOOKUP;
                else                  w_next = S_IDLE;
            end
            S_LOOKUP:  w_next = bus.st_hit ? S_RESP : S_MEM_REQ;
            S_MEM_REQ: w_next = bus.mem_ack ? S_FILL : S_MEM_REQ;
            S_FILL:    w_next = S_RESP;
            S_RESP:    w_next = S_IDLE;
            S_FLUSH:   w_next = w_flush_last ? S_IDLE : S_FLUSH;
            default:   w_next = S_IDLE;
        endcase
    end

    // Storage / memory / CPU-ready decode from the current state
    always_comb begin
        bus.cpu_ready      = 1'b0;
        bus.st_read        = 1'b0;
        bus.st_write       = 1'b0;
        bus.st_write_valid = 1'b0;
        bus.st_address     = 32'd0;
        bus.st_write_data  = '0;
        bus.st_write_tag   = '0;
        bus.st_way_select  = '0;
        bus.mem_req        = 1'b0;
        bus.mem_addr       = 32'd0;
        case (r_state)
            S_IDLE: begin
                bus.cpu_ready = 1'b1;
                if (!bus.flush && bus.cpu_req) begin
                    bus.st_read    = 1'b1;
                    bus.st_address = bus.cpu_addr;
                end else begin
                    bus.st_read    = 1'b0;
                end
            end
            S_MEM_REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = r_addr_q;
            end
            S_FILL: begin
                bus.st_write       = 1'b1;
                bus.st_write_valid = 1'b1;
                bus.st_address     = r_addr_q;
                bus.st_write_tag   = r_addr_q[31:32-TAG_BITS];
                bus.st_write_data  = r_rdata;
                bus.st_way_select  = w_victim_cur;
            end
            S_FLUSH: begin
                bus.st_write      = 1'b1;
                bus.st_address    = 32'(r_set);
                bus.st_way_select = r_way;
            end
            default: begin
                bus.cpu_ready = 1'b0;
            end
        endcase
    end

    // Datapath: request address, returned word, flush walk and victim pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr_q     <= 32'd0;
            r_rdata      <= '0;
            r_set        <= '0;
            r_way        <= '0;
            r_flush_done <= 1'b0;
            r_victim     <= '0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.flush) begin
                        r_set <= '0;
                        r_way <= '0;
                    end else if (bus.cpu_req) begin
                        r_addr_q <= bus.cpu_addr;
                    end
                end
                S_LOOKUP: begin
                    if (bus.st_hit) r_rdata <= bus.st_read_data;
                end
                S_MEM_REQ: begin
                    if (bus.mem_ack) r_rdata <= bus.mem_rdata;
                end
                S_FILL: begin
                    r_victim[int'(w_index)*WAY_BITS +: WAY_BITS] <= w_victim_cur + WAY_BITS'(1);
                end
                S_FLUSH: begin
                    // way is the fast counter; set advances when way wraps
                    r_way <= r_way + WAY_BITS'(1);
                    if (r_way == '1) r_set <= r_set + INDEX_BITS'(1);
                    if (w_flush_last) begin
                        r_flush_done <= 1'b1;
                        r_victim     <= '0;
                    end
                end
                default: begin
                    r_flush_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_SA_PERF_EN
    // Lookup outcome counters; free-running, untouched by flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else if (r_state == S_LOOKUP) begin
            if (bus.st_hit) hit_count  <= hit_count + 32'd1;
            else            miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule
